mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer that responds on the processor data bus alongside the data memory, using the same single-cycle `we`/`a`/`wd`/`rd` protocol: combinational read, write on the clock edge. It provides a prescaled up-counter, a compare register, a sticky match flag and an interrupt line. The top level muxes `rd` onto the processor's read data whenever `hit` is high.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: register window base; must be 32-byte aligned.
- `PRESCALE_W`, default 16: prescaler width in bits, 1..32.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `we` in 1: bus write strobe (processor memory-write signal).
- `a` in 32: bus byte address.
- `wd` in 32: bus write data.
- `rd` out 32: read data, combinational from `a`.
- `hit` out 1: combinational; high when `a[31:5] == BASE_ADDR[31:5]`.
- `irq` out 1: interrupt request, level, driven directly from registers.

## Operation
- Word offset is `a[4:2]`; `a[1:0]` is ignored.
- Register map:
  - 0x00 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IEN; other bits read 0.
  - 0x04 PRESCALE: `PRESCALE_W` bits, zero-extended on read.
  - 0x08 COUNT: 32 bits.
  - 0x0C COMPARE: 32 bits.
  - 0x10 STATUS: bit0 MATCH; write-1-to-clear.
  - 0x14–0x1C: read 0; writes ignored.
- `rd` is 0 when `hit` is low or the offset is unmapped.
- A register write requires `we & hit`.
- Prescaler (internal `pre`, not software-visible):
  - While EN=1: `pre` increments each cycle.
  - When `pre == PRESCALE`: `pre` returns to 0 and a one-cycle `tick` fires.
  - While EN=0: `pre` is held at 0.
- On `tick`:
  - If COUNT == COMPARE: set MATCH.
    - AUTO=1: COUNT <= 0.
    - AUTO=0: COUNT <= COUNT+1 and EN is cleared (one-shot).
  - Otherwise: COUNT <= COUNT+1, wrapping from 0xFFFF_FFFF to 0 with no flag.
- `irq = MATCH & IEN`.
- Simultaneous events (same cycle):
  - Software write to COUNT and `tick`: the written value wins.
  - A write to CTRL and a one-shot clear of EN: the written CTRL value wins.
  - W1C of MATCH and a new match: MATCH stays set.
  - A write to PRESCALE applies immediately. If the new value is below the current `pre`, `pre` keeps counting, wraps at 2^PRESCALE_W and then matches.
  - A write to COMPARE affects the compare on the next `tick`.

## Timing
- Reset (async assert) values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=0xFFFF_FFFF, MATCH=0, `pre`=0. `irq`=0 during and after reset.
- `rd` and `hit` are purely combinational and valid within the cycle `a` is driven.
- Written values are visible on `rd` from the cycle after the write edge.
- With PRESCALE=P and EN set at edge k: the first `tick` occurs in cycle k+P+1, and COUNT updates at that cycle's closing edge. `tick`s repeat every P+1 cycles.
- MATCH, and therefore `irq`, rises at the same edge that applies the matching `tick`.
- Reset asserted mid-count returns all state to reset values immediately; no pending tick survives.

## Configuration
- Macro: `MMIO_TIMER_IRQ_EN`.
- Defined:
  - IEN is implemented.
  - `irq = MATCH & IEN`.
- Undefined:
  - CTRL.bit2 reads 0 and writes to it are ignored.
  - `irq` is tied to 0.
  - MATCH is still set and still readable (polling only).

## Structure
- Package `mmio_timer_pkg` holds:
  - Register offset constants: `OFF_CTRL`, `OFF_PRESCALE`, `OFF_COUNT`, `OFF_COMPARE`, `OFF_STATUS`.
  - CTRL bit-index constants.
  - Reset-value constants.
- One sub-module, `timer_prescaler`:
  - Inputs: `clk`, `reset`, `en`, `limit[PRESCALE_W]`.
  - Output: `tick`.
- Address decode, the register file and the count/compare logic stay in `mmio_timer`.

## Test plan
- Reset then read: read every offset (0x00–0x1C) → COMPARE reads 0xFFFF_FFFF, all others read 0, `irq`=0; an address outside the window gives `hit`=0 and `rd`=0.
- Prescaled count: PRESCALE=3, EN=1 → COUNT reads 1, 2, 3 at 4, 8 and 12 cycles after enable.
- One-shot match: COMPARE=5, PRESCALE=0, CTRL=0b101 →
  - MATCH and `irq` assert at the tick where COUNT==5;
  - COUNT becomes 6 and EN reads 0;
  - writing 1 to STATUS drops `irq` the next cycle.
- Auto-reload: COMPARE=2, CTRL=0b011 → COUNT sequence 0, 1, 2, 0, 1, 2; MATCH stays set with no W1C.
- Collisions:
  - A COUNT write of 0x100 in the same cycle as a tick → COUNT reads 0x100.
  - A W1C of STATUS in the same cycle as a new match → MATCH stays 1.
  - COUNT=0xFFFF_FFFF then a tick → COUNT reads 0, MATCH unchanged.
- Mid-operation reset: assert `reset` while counting with `irq` high → `irq`, COUNT and CTRL clear asynchronously without waiting for a `clk` edge.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer_pkg
// Purpose  : Shared constants for the memory-mapped timer: register byte
//            offsets inside the 32-byte window, CTRL bit positions, reset
//            values and a helper that packs the CTRL read word.
// Ports    : (package, no ports)
// Config   : MMIO_TIMER_IRQ_EN (see mmio_timer)
// Revision : 1.0 - initial release
// ============================================================================
package mmio_timer_pkg;

    // Byte offsets within the register window. Decode compares these against
    // {a[4:2], 2'b00}, so the byte lane bits never take part.
    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_PRESCALE = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_COMPARE  = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int CTRL_IEN_BIT  = 2;

    // STATUS bit positions
    localparam int STATUS_MATCH_BIT = 0;

    // Reset values
    localparam logic        RST_EN      = 1'b0;
    localparam logic        RST_AUTO    = 1'b0;
    localparam logic        RST_IEN     = 1'b0;
    localparam logic        RST_MATCH   = 1'b0;
    localparam logic [31:0] RST_COUNT   = 32'h0000_0000;
    localparam logic [31:0] RST_COMPARE = 32'hFFFF_FFFF;

    // Pack the CTRL fields into the 32-bit read word; unused bits read 0.
    function automatic logic [31:0] ctrl_word(
        input logic en,
        input logic arl,
        input logic ien
    );
        logic [31:0] w;
        w                = 32'h0000_0000;
        w[CTRL_EN_BIT]   = en;
        w[CTRL_AUTO_BIT] = arl;
        w[CTRL_IEN_BIT]  = ien;
        return w;
    endfunction

endpackage : mmio_timer_pkg
`default_nettype wire

// File: rtl/mmio_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : timer_prescaler
// Purpose  : Free-running divider for the timer. While enabled the internal
//            counter climbs every cycle; when it equals 'limit' it returns to
//            zero and 'tick' is high for that cycle, giving one tick every
//            limit+1 cycles. Disabled holds the counter at zero.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-high reset
//            en    - count enable (timer CTRL.EN)
//            limit - terminal count (timer PRESCALE register)
//            tick  - one-cycle pulse, combinational from registers
// Revision : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] limit,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_pre;
    logic                  w_at_limit;

    // Equality only: if software lowers 'limit' below the current count the
    // counter runs on, wraps through 2^PRESCALE_W and matches on the way up.
    assign w_at_limit = (r_pre == limit);
    assign tick       = en & w_at_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (!en || w_at_limit) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRESCALE_W'(1);
        end
    end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer
// Purpose  : Memory-mapped timer on the processor data bus. Single-cycle
//            protocol: combinational read, write on the rising clock edge.
//            Prescaled 32-bit up-counter, compare register, sticky MATCH flag
//            (write-1-to-clear) and a level interrupt.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-high reset
//            we    - bus write strobe
//            a     - bus byte address (word offset a[4:2], a[1:0] ignored)
//            wd    - bus write data
//            rd    - read data, combinational, 0 when not selected/unmapped
//            hit   - combinational window select (a[31:5] == BASE_ADDR[31:5])
//            irq   - interrupt request, MATCH & IEN
// Config   : MMIO_TIMER_IRQ_EN - when defined, CTRL.IEN exists and drives irq.
//            When undefined, IEN reads 0, writes to it are ignored and irq is
//            tied low; MATCH remains available for polling.
// Map      : 0x00 CTRL {IEN,AUTO,EN}  0x04 PRESCALE  0x08 COUNT
//            0x0C COMPARE  0x10 STATUS {MATCH}  0x14-0x1C read 0
// Revision : 1.0 - initial release
// ============================================================================
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        irq
);

    import mmio_timer_pkg::*;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [4:0] w_off;
    logic       w_wr;
    logic       w_wr_ctrl;
    logic       w_wr_prescale;
    logic       w_wr_count;
    logic       w_wr_compare;
    logic       w_wr_status;
    logic       w_unused;

    assign hit           = (a[31:5] == BASE_ADDR[31:5]);
    assign w_off         = {a[4:2], 2'b00};
    assign w_wr          = we & hit;
    assign w_wr_ctrl     = w_wr && (w_off == OFF_CTRL);
    assign w_wr_prescale = w_wr && (w_off == OFF_PRESCALE);
    assign w_wr_count    = w_wr && (w_off == OFF_COUNT);
    assign w_wr_compare  = w_wr && (w_off == OFF_COMPARE);
    assign w_wr_status   = w_wr && (w_off == OFF_STATUS);

    // Byte-lane bits are deliberately not decoded.
    assign w_unused = &{1'b0, a[1:0]};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                  r_en;
    logic                  r_auto;
    logic                  w_ien;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic                  r_match;

    logic                  w_tick;
    logic                  w_cmp_eq;
    logic                  w_hit_match;

    assign w_cmp_eq    = (r_count == r_compare);
    assign w_hit_match = w_tick & w_cmp_eq;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (r_en),
        .limit (r_prescale),
        .tick  (w_tick)
    );

    // CTRL. A one-shot match clears EN, but a same-cycle software write to
    // CTRL is applied last and therefore takes precedence.
`ifdef MMIO_TIMER_IRQ_EN
    logic r_ien;
    assign w_ien = r_ien;
`else
    assign w_ien = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en   <= RST_EN;
            r_auto <= RST_AUTO;
`ifdef MMIO_TIMER_IRQ_EN
            r_ien  <= RST_IEN;
`endif
        end else begin
            if (w_hit_match && !r_auto) begin
                r_en <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_en   <= wd[CTRL_EN_BIT];
                r_auto <= wd[CTRL_AUTO_BIT];
`ifdef MMIO_TIMER_IRQ_EN
                r_ien  <= wd[CTRL_IEN_BIT];
`endif
            end
        end
    end

    // PRESCALE feeds the prescaler compare directly, so a write takes effect
    // from the very next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (w_wr_prescale) begin
            r_prescale <= wd[PRESCALE_W-1:0];
        end
    end

    // COUNT. Software writes override a coincident tick. On a match the
    // counter either reloads to zero (AUTO) or keeps climbing (one-shot);
    // the natural 32-bit wrap raises no flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= RST_COUNT;
        end else if (w_wr_count) begin
            r_count <= wd;
        end else if (w_tick) begin
            if (w_cmp_eq && r_auto) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // COMPARE is sampled by the tick logic, so a new value is seen on the
    // first tick after the write edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_compare <= RST_COMPARE;
        end else if (w_wr_compare) begin
            r_compare <= wd;
        end
    end

    // MATCH is sticky; a new match outranks a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match <= RST_MATCH;
        end else if (w_hit_match) begin
            r_match <= 1'b1;
        end else if (w_wr_status && wd[STATUS_MATCH_BIT]) begin
            r_match <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_rd;

    always_comb begin
        w_rd = 32'h0000_0000;
        if (hit) begin
            case (w_off)
                OFF_CTRL:     w_rd = ctrl_word(r_en, r_auto, w_ien);
                OFF_PRESCALE: w_rd = 32'(r_prescale);
                OFF_COUNT:    w_rd = r_count;
                OFF_COMPARE:  w_rd = r_compare;
                OFF_STATUS:   w_rd = {31'd0, r_match};
                default:      w_rd = 32'h0000_0000;
            endcase
        end
    end

    assign rd = w_rd;

    // ------------------------------------------------------------------
    // Interrupt: AND of two flops, so it rises on the edge that sets MATCH
    // ------------------------------------------------------------------
`ifdef MMIO_TIMER_IRQ_EN
    assign irq = r_match & r_ien;
`else
    assign irq = 1'b0;
`endif

endmodule : mmio_timer
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_timer
// Purpose  : Directed self-checking bench for mmio_timer. Inputs change 1 ns
//            after the rising edge; outputs are read within the same cycle.
// Config   : follows MMIO_TIMER_IRQ_EN for IEN/irq expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_timer;

    localparam logic [31:0] B = 32'hFFFF_0000;
`ifdef MMIO_TIMER_IRQ_EN
    localparam logic        IRQ_ON  = 1'b1;
    localparam logic [31:0] IEN_BIT = 32'h4;
`else
    localparam logic        IRQ_ON  = 1'b0;
    localparam logic [31:0] IEN_BIT = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_timer #(
        .BASE_ADDR  (B),
        .PRESCALE_W (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .hit   (hit),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // ---------------- bus helpers (no checking inside) ----------------
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1; a = addr; wd = data;
        @(posedge clk); #1;
        we = 1'b0; a = 32'h0; wd = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        we = 1'b0; a = addr;
        #1;
        data = rd;
    endtask

    task automatic apply_reset();
        reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] e;
        reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_in_reset: got %b expected 0", irq); end
        #1 reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            bus_read(B + 32'(i * 4), v);
            e = (i == 3) ? 32'hFFFF_FFFF : 32'h0;
            n_checks++;
            if (v !== e) begin n_fail++; $display("FAIL reset_read off=%0h: got %h expected %h", i * 4, v, e); end
            n_checks++;
            if (hit !== 1'b1) begin n_fail++; $display("FAIL reset_hit off=%0h: got %b expected 1", i * 4, hit); end
        end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_reset: got %b expected 0", irq); end
        bus_read(32'h0000_000C, v);
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL outside_hit: got %b expected 0", hit); end
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL outside_rd: got %h expected 0", v); end
        bus_read(B + 32'h0F, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL byte_lane_ignored: got %h expected ffffffff", v); end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        apply_reset();
        bus_write(32'h1234_5608, 32'hAA);
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL write_outside_window: got %h expected 0", v); end
        bus_write(B + 32'h14, 32'h77);
        bus_read(B + 32'h14, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_write: got %h expected 0", v); end
        bus_write(B + 32'h0A, 32'h55);
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'h55) begin n_fail++; $display("FAIL count_write: got %h expected 55", v); end
        bus_write(B + 32'h04, 32'hABCD_1234);
        bus_read(B + 32'h04, v);
        n_checks++;
        if (v !== 32'h0000_1234) begin n_fail++; $display("FAIL prescale_zext: got %h expected 00001234", v); end
        bus_write(B + 32'h00, 32'hFFFF_FFF8);
        bus_read(B + 32'h00, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL ctrl_reserved: got %h expected 0", v); end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        logic [31:0] e;
        apply_reset();
        bus_write(B + 32'h04, 32'd3);
        bus_write(B + 32'h00, 32'h1);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            bus_read(B + 32'h08, v);
            e = 32'(i / 4);
            n_checks++;
            if (v !== e) begin n_fail++; $display("FAIL prescale_count cyc=%0d: got %h expected %h", i, v, e); end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        logic [31:0] e;
        logic        m;
        apply_reset();
        bus_write(B + 32'h0C, 32'd5);
        bus_write(B + 32'h00, 32'h5);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            m = (i >= 6);
            bus_read(B + 32'h08, v);
            e = (i < 6) ? 32'(i) : 32'd6;
            n_checks++;
            if (v !== e) begin n_fail++; $display("FAIL oneshot_count cyc=%0d: got %h expected %h", i, v, e); end
            bus_read(B + 32'h10, v);
            n_checks++;
            if (v !== {31'd0, m}) begin n_fail++; $display("FAIL oneshot_match cyc=%0d: got %h expected %h", i, v, {31'd0, m}); end
            bus_read(B + 32'h00, v);
            e = ((i < 6) ? 32'h1 : 32'h0) | IEN_BIT;
            n_checks++;
            if (v !== e) begin n_fail++; $display("FAIL oneshot_ctrl cyc=%0d: got %h expected %h", i, v, e); end
            n_checks++;
            if (irq !== (m & IRQ_ON)) begin n_fail++; $display("FAIL oneshot_irq cyc=%0d: got %b expected %b", i, irq, m & IRQ_ON); end
        end
        bus_write(B + 32'h10, 32'h1);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b expected 0", irq); end
        bus_read(B + 32'h10, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_status: got %h expected 0", v); end
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'd6) begin n_fail++; $display("FAIL oneshot_hold: got %h expected 6", v); end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        logic [31:0] e;
        apply_reset();
        bus_write(B + 32'h0C, 32'd2);
        bus_write(B + 32'h00, 32'h3);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            bus_read(B + 32'h08, v);
            e = 32'(i % 3);
            n_checks++;
            if (v !== e) begin n_fail++; $display("FAIL auto_count cyc=%0d: got %h expected %h", i, v, e); end
            bus_read(B + 32'h10, v);
            e = (i >= 3) ? 32'h1 : 32'h0;
            n_checks++;
            if (v !== e) begin n_fail++; $display("FAIL auto_match cyc=%0d: got %h expected %h", i, v, e); end
            bus_read(B + 32'h00, v);
            n_checks++;
            if (v !== 32'h3) begin n_fail++; $display("FAIL auto_ctrl cyc=%0d: got %h expected 3", i, v); end
        end
    endtask

    task automatic test_collisions();
        logic [31:0] v;
        // COUNT write coincident with a tick
        apply_reset();
        bus_write(B + 32'h00, 32'h1);
        bus_write(B + 32'h08, 32'h100);
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'h100) begin n_fail++; $display("FAIL count_write_vs_tick: got %h expected 00000100", v); end
        @(posedge clk); #1;
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'h101) begin n_fail++; $display("FAIL count_after_write: got %h expected 00000101", v); end
        // W1C coincident with a new match (COMPARE=0, AUTO: match every tick)
        apply_reset();
        bus_write(B + 32'h0C, 32'h0);
        bus_write(B + 32'h00, 32'h3);
        bus_write(B + 32'h10, 32'h1);
        bus_read(B + 32'h10, v);
        n_checks++;
        if (v !== 32'h1) begin n_fail++; $display("FAIL w1c_vs_match: got %h expected 1", v); end
        // 32-bit wrap raises no flag
        apply_reset();
        bus_write(B + 32'h0C, 32'd5);
        bus_write(B + 32'h08, 32'hFFFF_FFFF);
        bus_write(B + 32'h00, 32'h1);
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_pre: got %h expected ffffffff", v); end
        @(posedge clk); #1;
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL wrap_count: got %h expected 0", v); end
        bus_read(B + 32'h10, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL wrap_match: got %h expected 0", v); end
    endtask

    task automatic test_midrun_reset();
        logic [31:0] v;
        apply_reset();
        bus_write(B + 32'h0C, 32'd2);
        bus_write(B + 32'h00, 32'h7);
        repeat (4) @(posedge clk);
        #1;
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL midrun_count_pre: got %h expected 1", v); end
        n_checks++;
        if (irq !== IRQ_ON) begin n_fail++; $display("FAIL midrun_irq_pre: got %b expected %b", irq, IRQ_ON); end
        // Assert reset between clock edges; everything must clear at once.
        reset = 1'b1;
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL midrun_irq_async: got %b expected 0", irq); end
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL midrun_count_async: got %h expected 0", v); end
        bus_read(B + 32'h00, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL midrun_ctrl_async: got %h expected 0", v); end
        bus_read(B + 32'h10, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL midrun_status_async: got %h expected 0", v); end
        reset = 1'b0;
        @(posedge clk); #1;
        bus_read(B + 32'h08, v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL midrun_no_tick: got %h expected 0", v); end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0;
        test_reset();
        test_decode();
        test_prescale();
        test_oneshot();
        test_autoreload();
        test_collisions();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mmio_timer
`default_nettype wire
